// File: rtl/octa16_pkg.sv
// Octa16 shared definitions: ALU op codes, decoder FSM states, instruction
// field positions and op classification helpers.
package octa16_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  typedef enum logic [1:0] {
    S_LO    = 2'd0,
    S_HI    = 2'd1,
    S_ISSUE = 2'd2
  } dec_state_e;

  localparam int unsigned OP_MSB      = 15;
  localparam int unsigned OP_LSB      = 12;
  localparam int unsigned RD_MSB      = 11;
  localparam int unsigned RD_LSB      = 9;
  localparam int unsigned RS1_MSB     = 8;
  localparam int unsigned RS1_LSB     = 6;
  localparam int unsigned IMM_SEL_BIT = 5;
  localparam int unsigned IMM5_MSB    = 4;
  localparam int unsigned RS2_MSB     = 2;

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_OR, ALU_AND,
      ALU_SUB, ALU_SRA: is_legal = 1'b1;
      default:          is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_shift(input logic [3:0] op);
    case (op)
      ALU_SLL, ALU_SRL, ALU_SRA: is_shift = 1'b1;
      default:                   is_shift = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/inst_field_decode.sv
// Purely combinational split of a 16-bit Octa16 instruction into ALU
// control, register addresses and the extended immediate.
module inst_field_decode
  import octa16_pkg::*;
(
  input  logic [15:0] instr,
  output logic [3:0]  alu_ctl,
  output logic [2:0]  rd,
  output logic [2:0]  rs1,
  output logic [2:0]  rs2,
  output logic [7:0]  imm,
  output logic        use_imm,
  output logic        wr_en,
  output logic        illegal
);

  logic [4:0] imm5;

  // Field extraction, legality and immediate extension
  always_comb begin
    alu_ctl = instr[OP_MSB:OP_LSB];
    rd      = instr[RD_MSB:RD_LSB];
    rs1     = instr[RS1_MSB:RS1_LSB];
    rs2     = instr[RS2_MSB:0];
    use_imm = instr[IMM_SEL_BIT];
    imm5    = instr[IMM5_MSB:0];
    illegal = ~is_legal(alu_ctl);
    wr_en   = is_legal(alu_ctl);
    imm     = '0;
    if (use_imm) begin
      if (is_shift(alu_ctl))
        imm = {3'b000, imm5};
      else
        imm = {{3{imm5[4]}}, imm5};
    end
  end

endmodule

// File: rtl/alu_inst_decoder.sv
// Octa16 front-end: assembles two-byte instructions from a byte stream,
// decodes them and issues the registered bundle downstream.
module alu_inst_decoder
  import octa16_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] alu_ctl,
  output logic [2:0] rd,
  output logic [2:0] rs1,
  output logic [2:0] rs2,
  output logic [7:0] imm,
  output logic       use_imm,
  output logic       wr_en,
  output logic       illegal,
  output logic [7:0] issue_cnt
);

  dec_state_e state_q, state_d;
  logic [7:0] lo_byte_q;
  logic       in_hs, out_hs;
  logic       cap_lo, cap_hi;

  logic [3:0] dec_alu_ctl;
  logic [2:0] dec_rd, dec_rs1, dec_rs2;
  logic [7:0] dec_imm;
  logic       dec_use_imm, dec_wr_en, dec_illegal;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;
  assign cap_lo = in_hs & ~flush & (state_q == S_LO);
  assign cap_hi = in_hs & ~flush & (state_q == S_HI);

  inst_field_decode u_dec (
    .instr   ({in_byte, lo_byte_q}),
    .alu_ctl (dec_alu_ctl),
    .rd      (dec_rd),
    .rs1     (dec_rs1),
    .rs2     (dec_rs2),
    .imm     (dec_imm),
    .use_imm (dec_use_imm),
    .wr_en   (dec_wr_en),
    .illegal (dec_illegal)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_LO;
    else     state_q <= state_d;
  end

  // Next-state: byte handshakes advance LO->HI->ISSUE, out handshake returns; flush overrides
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LO:    if (in_valid)  state_d = S_HI;
      S_HI:    if (in_valid)  state_d = S_ISSUE;
      S_ISSUE: if (out_ready) state_d = S_LO;
      default:                state_d = S_LO;
    endcase
    if (flush) state_d = S_LO;
  end

  // Output decode: in_ready is the only combinational output, held low in reset
  always_comb begin
    in_ready = ~rst & (state_q != S_ISSUE);
  end

  // Low byte capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         lo_byte_q <= '0;
    else if (cap_lo) lo_byte_q <= in_byte;
  end

  // Decoded bundle registers, loaded as the high byte arrives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_ctl <= '0;
      rd      <= '0;
      rs1     <= '0;
      rs2     <= '0;
      imm     <= '0;
      use_imm <= 1'b0;
      wr_en   <= 1'b0;
      illegal <= 1'b0;
    end else if (cap_hi) begin
      alu_ctl <= dec_alu_ctl;
      rd      <= dec_rd;
      rs1     <= dec_rs1;
      rs2     <= dec_rs2;
      imm     <= dec_imm;
      use_imm <= dec_use_imm;
      wr_en   <= dec_wr_en;
      illegal <= dec_illegal;
    end
  end

  // out_valid: set on high-byte capture, cleared by issue or flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         out_valid <= 1'b0;
    else if (flush)  out_valid <= 1'b0;
    else if (cap_hi) out_valid <= 1'b1;
    else if (out_hs) out_valid <= 1'b0;
  end

  // Issue counter, wraps naturally; a flushed handshake does not count
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  issue_cnt <= '0;
    else if (out_hs && !flush) issue_cnt <= issue_cnt + 8'd1;
  end

endmodule

// File: tb/tb_alu_inst_decoder.sv
// Directed, table-driven bench for alu_inst_decoder.
module tb_alu_inst_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] alu_ctl;
  logic [2:0] rd, rs1, rs2;
  logic [7:0] imm;
  logic       use_imm, wr_en, illegal;
  logic [7:0] issue_cnt;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_cnt;

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic [3:0] alu;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [7:0] imm;
    logic       use_imm;
    logic       wr_en;
    logic       illegal;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  alu_inst_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_ctl   (alu_ctl),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .use_imm   (use_imm),
    .wr_en     (wr_en),
    .illegal   (illegal),
    .issue_cnt (issue_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_bundle(input vec_t v);
    chk("out_valid", {31'd0, out_valid}, 32'd1);
    chk("alu_ctl",   {28'd0, alu_ctl}, {28'd0, v.alu});
    chk("rd",        {29'd0, rd},      {29'd0, v.rd});
    chk("rs1",       {29'd0, rs1},     {29'd0, v.rs1});
    if (!v.use_imm) chk("rs2", {29'd0, rs2}, {29'd0, v.rs2});
    chk("imm",       {24'd0, imm},     {24'd0, v.imm});
    chk("use_imm",   {31'd0, use_imm}, {31'd0, v.use_imm});
    chk("wr_en",     {31'd0, wr_en},   {31'd0, v.wr_en});
    chk("illegal",   {31'd0, illegal}, {31'd0, v.illegal});
  endtask

  // Called just after a posedge; returns #1 after the accepting edge.
  task automatic put_byte(input logic [7:0] b);
    int n = 0;
    in_byte  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic take_out();
    int n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    chk("issue_cnt", {24'd0, issue_cnt}, {24'd0, exp_cnt});
    chk("out_valid_after_issue", {31'd0, out_valid}, 32'd0);
    chk("in_ready_after_issue", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    vec_t sub_v, add_v;
    rst = 1'b1; flush = 1'b0; in_byte = '0; in_valid = 1'b0; out_ready = 1'b0;
    exp_cnt = '0;

    //                lo     hi     alu   rd    rs1   rs2   imm    ui wr il
    vecs[0] = '{8'h2A, 8'h05, 4'h0, 3'd2, 3'd4, 3'd2, 8'h0A, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h83, 8'h82, 4'h8, 3'd1, 3'd2, 3'd3, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h3F, 8'h00, 4'h0, 3'd0, 3'd0, 3'd7, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h3F, 8'h10, 4'h1, 3'd0, 3'd0, 3'd7, 8'h1F, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h00, 8'h90, 4'h9, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h70, 8'hDB, 4'hD, 3'd5, 3'd5, 3'd0, 8'h10, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'h30, 8'h8E, 4'h8, 3'd7, 3'd0, 3'd0, 8'hF0, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{8'h9D, 8'h57, 4'h5, 3'd3, 3'd6, 3'd5, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{8'h3F, 8'hF0, 4'hF, 3'd0, 3'd0, 3'd7, 8'hFF, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{8'h0F, 8'h20, 4'h2, 3'd0, 3'd0, 3'd7, 8'h00, 1'b0, 1'b1, 1'b0};
    add_v = vecs[0];
    sub_v = vecs[1];

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_fields", {11'd0, alu_ctl, rd, rs1, rs2, imm, use_imm, wr_en, illegal}, 32'd0);
    chk("rst_cnt", {24'd0, issue_cnt}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Table of single instructions
    for (int unsigned i = 0; i < 10; i++) begin
      put_byte(vecs[i].lo);
      chk("hi_phase_no_valid", {31'd0, out_valid}, 32'd0);
      put_byte(vecs[i].hi);
      chk_bundle(vecs[i]);
      take_out();
    end

    // Back-pressure: bundle held for 5 cycles, stray bytes ignored
    put_byte(8'h2A);
    put_byte(8'h05);
    in_byte  = 8'hFF;
    in_valid = 1'b1;
    for (int unsigned c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk_bundle(add_v);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_cnt", {24'd0, issue_cnt}, {24'd0, exp_cnt});
    end
    in_valid = 1'b0;
    take_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("single_issue", {24'd0, issue_cnt}, {24'd0, exp_cnt});

    // Flush after the low byte: next bytes start a fresh instruction
    put_byte(8'h00);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_lo_cnt", {24'd0, issue_cnt}, {24'd0, exp_cnt});
    chk("flush_lo_valid", {31'd0, out_valid}, 32'd0);
    put_byte(sub_v.lo);
    put_byte(sub_v.hi);
    chk_bundle(sub_v);

    // Flush coincident with the out handshake
    out_ready = 1'b1;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    flush     = 1'b0;
    chk("flush_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_hs_cnt", {24'd0, issue_cnt}, {24'd0, exp_cnt});
    chk("flush_hs_in_ready", {31'd0, in_ready}, 32'd1);
    put_byte(add_v.lo);
    put_byte(add_v.hi);
    chk_bundle(add_v);
    take_out();

    // Reset asserted while waiting for the high byte
    put_byte(8'h83);
    rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_fields", {11'd0, alu_ctl, rd, rs1, rs2, imm, use_imm, wr_en, illegal}, 32'd0);
    chk("rst_mid_cnt", {24'd0, issue_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = '0;
    @(posedge clk);
    #1;

    // Counter wrap over 256 issues
    for (int unsigned k = 0; k < 256; k++) begin
      put_byte(8'h00);
      put_byte(8'h00);
      take_out();
      if (k == 254) chk("cnt_at_ff", {24'd0, issue_cnt}, 32'h0000_00FF);
    end
    chk("cnt_wrap", {24'd0, issue_cnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_inst_decoder.md
# alu_inst_decoder

- Front-end control block for the Octa16 datapath.
- Accepts 16-bit instructions as two 8-bit bytes over a valid/ready stream, low byte first.
- Decodes each instruction into the 4-bit ALU control code, register addresses and an extended 8-bit immediate.
- Issues the decoded bundle to the register-file/ALU stage over a second valid/ready handshake and keeps a running issue count.

## Interface
- No parameters: widths are fixed by the Octa16 ISA (8-bit data, 16-bit instruction, 4-bit ALU control).
- Clocking and reset (already decided): one clock; reset is asynchronous and active-high.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous abort: discards any partial or pending instruction.
- in_byte  in  8  instruction byte.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  decoder accepts a byte this cycle.
- out_valid  out  1  decoded bundle is valid.
- out_ready  in  1  downstream accepts the bundle.
- alu_ctl  out  4  ALU control code, equal to instr[15:12].
- rd / rs1 / rs2  out  3 each  register addresses.
- imm  out  8  extended immediate.
- use_imm  out  1  ALU operand 2 is imm, not rs2.
- wr_en  out  1  write rd; 0 for illegal ops.
- illegal  out  1  alu_ctl is an unassigned code.
- issue_cnt  out  8  number of bundles issued.

## Operation
- Instruction fields:
  - [15:12] op
  - [11:9] rd
  - [8:6] rs1
  - [5] imm_sel
  - [4:0] imm5 when imm_sel=1; when imm_sel=0, [2:0] is rs2 and [4:3] is ignored.
- Legal op codes:
  - 0000 ADD, 0001 SLL, 0010 SLT, 0011 SLTU
  - 0100 XOR, 0101 SRL, 0110 OR, 0111 AND
  - 1000 SUB, 1101 SRA
- Illegal op codes: 1001, 1010, 1011, 1100, 1110, 1111. For these, illegal=1 and wr_en=0; all other fields decode normally.
- Immediate extension:
  - Shift ops (SLL, SRL, SRA): imm = zero-extended imm5.
  - All other ops: imm = imm5 sign-extended to 8 bits.
  - imm_sel=0: imm=0.
- State machine, S_LO at reset:
  - S_LO: in_ready=1; a byte handshake captures the low byte → S_HI.
  - S_HI: in_ready=1; a byte handshake captures the high byte, registers all decoded outputs, sets out_valid → S_ISSUE.
  - S_ISSUE: in_ready=0; out_valid=1 and all outputs held stable until out_ready; on the handshake, issue_cnt increments → S_LO.
- flush, any state:
  - Next state is S_LO and out_valid clears; the captured low byte is discarded.
  - issue_cnt does not change.
  - flush wins over a coincident in or out handshake.
- issue_cnt wraps from 0xFF to 0x00 and counts illegal issues as well.
- in_valid without in_ready does nothing; in_byte is ignored in S_ISSUE.

## Timing
- Reset values: state S_LO, out_valid=0, in_ready=0 while rst is high and 1 after release; all decoded outputs 0; issue_cnt=0.
- Latency: high byte accepted at edge N → out_valid=1 from edge N, i.e. decoded values are visible in cycle N+1.
- Throughput: at best 3 cycles per instruction (LO, HI, ISSUE).
- Out handshake at edge M: out_valid=0 and in_ready=1 from edge M.
- Reset asserted mid-instruction: immediately returns to the reset values; the partial instruction is lost.
- All outputs are registered; only in_ready is decoded combinationally from state and rst.

## Structure
- Shared package octa16_pkg holds:
  - alu_op_e, a 4-bit enum of the ten legal codes (values as above). The ALU uses the same enum.
  - dec_state_e {S_LO, S_HI, S_ISSUE}.
  - Field position constants.
  - is_shift() and is_legal() functions.
- Sub-module inst_field_decode: purely combinational, 16-bit instr → {alu_ctl, rd, rs1, rs2, imm, use_imm, wr_en, illegal}.
- The top level owns the FSM, the byte register, the output registers and issue_cnt.

## Test plan
- Bytes 0x2A then 0x05 (instr 0x052A), out_ready=1 → alu_ctl=0000, rd=2, rs1=4, use_imm=1, imm=0x0A, wr_en=1; issue_cnt 0→1.
- Bytes 0x83 then 0x82 (instr 0x8283) → SUB: alu_ctl=1000, rd=1, rs1=2, rs2=3, use_imm=0, imm=0.
- Instr 0x003F (ADD, imm5=11111) → imm=0xFF. Instr 0x103F (SLL, imm5=11111) → imm=0x1F.
- Instr 0x9000 → illegal=1, wr_en=0, alu_ctl=1001; issue_cnt still increments.
- out_ready held 0 for 5 cycles → out_valid and all fields stable, in_ready=0; then out_ready=1 → one issue only.
- flush after the low byte, and flush coincident with an out handshake → next byte is taken as a low byte, issue_cnt unchanged. Separately, 256 issues → issue_cnt returns to 0x00. Separately, rst mid-HI → all outputs 0.
